tube_scan_ctrl: RTL and testbench

//   Parametrised multiplexed 7-seg/tube digit scanner; next generation of the Tube digit selector.

---
 rtl/tube_pkg.sv | 25 ++
 rtl/tube_next_idx.sv | 44 ++++
 rtl/tube_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_tube_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tube_pkg
//  Description : Shared constants and helpers for the tube digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package tube_pkg;

    // Default geometry of the scanner
    localparam int DEFAULT_DIGITS = 6;
    localparam int DEFAULT_NUM_W  = 5;

    // Widest digit-select bus the helper below can describe
    localparam int MAX_DIGITS = 32;

    // Brightness code meaning "digit on for the whole PWM period"
    localparam logic [3:0] BRIGHT_FULL = 4'hF;

    // All selects inactive (active-low bus, so all ones); slice to DIGITS bits
    function automatic logic [MAX_DIGITS-1:0] dig_off();
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tube_next_idx.sv
`default_nettype none
// ============================================================================
//  Module      : tube_next_idx
//  Description : Circular priority search for the next enabled digit below
//                the current one, plus "current digit opens the frame" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_next_idx #(
    parameter int DIGITS = 6,
    parameter int IDX_W  = 3
) (
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DIGITS-1:0] dig_en_i,
    output logic [IDX_W-1:0]  next_idx_o,
    output logic              is_first_o,
    output logic              any_en_o
);

    int               w_cand;
    logic [IDX_W-1:0] w_hi;

    // Nearest enabled index below idx (wrapping), highest enabled index overall
    always_comb begin
        next_idx_o = idx_i;
        any_en_o   = |dig_en_i;
        w_hi       = '0;
        w_cand     = 0;
        // Walk from the farthest candidate to the nearest so the nearest wins
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_cand = (int'(idx_i) >= k) ? (int'(idx_i) - k) : (int'(idx_i) + DIGITS - k);
            if (dig_en_i[w_cand]) begin
                next_idx_o = IDX_W'(w_cand);
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_en_i[i]) begin
                w_hi = IDX_W'(i);
            end
        end
        is_first_o = any_en_o && (w_hi == idx_i);
    end

endmodule
`default_nettype wire

// File: rtl/tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tube_scan_ctrl
//  Description : Multiplexed tube / 7-seg digit scanner with programmable slot
//                length, anti-ghost blanking, 16-level PWM brightness,
//                disabled-digit skipping and frame-latched digit codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int DIGITS  = DEFAULT_DIGITS,
    parameter int NUM_W   = DEFAULT_NUM_W,
    parameter int PRESC_W = 16,
    parameter int BLANK   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRESC_W-1:0]      scan_div,
    input  logic [3:0]              bright,
    input  logic [DIGITS-1:0]       dig_en,
    input  logic [DIGITS*NUM_W-1:0] nums,
    output logic [DIGITS-1:0]       DIG,
    output logic [NUM_W-1:0]        num,
    output logic                    frame_start
);

    localparam int                    IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [MAX_DIGITS-1:0] ALL_OFF     = dig_off();
    localparam logic [DIGITS-1:0]     DIG_ALL_OFF = ALL_OFF[DIGITS-1:0];
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [PRESC_W-1:0]    BLANK_CNT   = PRESC_W'(BLANK);

    // Scan state
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic [PRESC_W-1:0]      slot_cnt_q,   slot_cnt_d;
    logic [3:0]              pwm_cnt_q,    pwm_cnt_d;
    logic [DIGITS*NUM_W-1:0] shadow_q,     shadow_d;

    // Output registers
    logic [DIGITS-1:0]       dig_q,        dig_d;
    logic [NUM_W-1:0]        num_q,        num_d;
    logic                    frame_start_q, frame_start_d;

    // Search results and per-cycle decisions
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_is_first;
    logic                    w_any_en;
    logic [PRESC_W-1:0]      w_slot_len;
    logic                    w_slot_end;
    logic                    w_frame_begin;
    logic                    w_pwm_on;
    logic                    w_drive;

    tube_next_idx #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_next_idx (
        .idx_i      (idx_q),
        .dig_en_i   (dig_en),
        .next_idx_o (w_next_idx),
        .is_first_o (w_is_first),
        .any_en_o   (w_any_en)
    );

    // Next-state and next-output computation for one clock
    always_comb begin
        // A zero divider would give a 1-cycle slot; clamp it to 2 cycles
        w_slot_len    = (scan_div == '0) ? PRESC_W'(1) : scan_div;
        // >= rather than == so shrinking scan_div mid-slot cannot lock up
        w_slot_end    = (slot_cnt_q >= w_slot_len);
        // Frame opens on the first cycle of the highest enabled digit's slot
        w_frame_begin = (slot_cnt_q == '0) && w_is_first;
        w_pwm_on      = (bright == BRIGHT_FULL) || (pwm_cnt_q <= bright);
        w_drive       = w_any_en && dig_en[idx_q] && (slot_cnt_q >= BLANK_CNT) && w_pwm_on;

        slot_cnt_d    = w_slot_end ? '0 : (slot_cnt_q + PRESC_W'(1));
        idx_d         = w_slot_end ? w_next_idx : idx_q;
        pwm_cnt_d     = pwm_cnt_q + 4'd1;
        shadow_d      = w_frame_begin ? nums : shadow_q;

        dig_d         = w_drive ? ~(DIGITS'(1) << idx_q) : DIG_ALL_OFF;
        // Code follows the scan position regardless of drive, from the latched frame
        num_d         = shadow_q[idx_q*NUM_W +: NUM_W];
        frame_start_d = w_frame_begin;
    end

    // Scan counters, digit index and frame shadow of the codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= IDX_LAST;
            slot_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            shadow_q   <= '0;
        end else begin
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            shadow_q   <= shadow_d;
        end
    end

    // Registered outputs, forced inactive while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q         <= DIG_ALL_OFF;
            num_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            dig_q         <= dig_d;
            num_q         <= num_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign DIG         = dig_q;
    assign num         = num_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tube_scan_ctrl
//  Description : Directed self-checking bench for tube_scan_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] scan_div;
    logic [3:0]  bright;
    logic [5:0]  dig_en;
    logic [29:0] nums;
    logic [5:0]  DIG;
    logic [4:0]  num;
    logic        frame_start;

    int checks;
    int failures;

    logic [29:0] nums_a;
    logic [29:0] nums_b;

    tube_scan_ctrl #(
        .DIGITS  (6),
        .NUM_W   (5),
        .PRESC_W (16),
        .BLANK   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_div    (scan_div),
        .bright      (bright),
        .dig_en      (dig_en),
        .nums        (nums),
        .DIG         (DIG),
        .num         (num),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] dg(input logic [29:0] v, input int i);
        return v[i*5 +: 5];
    endfunction

    function automatic logic [5:0] sel(input int i);
        logic [5:0] one;
        one = 6'd1;
        return ~(one << i);
    endfunction

    // Hold reset for two edges; release just after an edge so the next edge is cycle 0
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Full-brightness scan, all digits, 4-cycle slots
    task automatic test_scan();
        int idx;
        logic [5:0] e_dig;
        logic [4:0] e_num;
        logic       e_fs;
        scan_div = 16'd3; bright = 4'hF; dig_en = 6'h3F; nums = nums_a;
        apply_reset();
        for (int k = 0; k < 48; k++) begin
            @(posedge clk); #1;
            idx   = 5 - ((k / 4) % 6);
            e_dig = ((k % 4) >= 2) ? sel(idx) : 6'h3F;
            e_fs  = ((k % 24) == 0);
            e_num = (k == 0) ? 5'd0 : dg(nums_a, idx);
            checks++;
            if (DIG !== e_dig) begin
                failures++;
                $display("FAIL scan_dig k=%0d got=%h exp=%h", k, DIG, e_dig);
            end
            checks++;
            if (frame_start !== e_fs) begin
                failures++;
                $display("FAIL scan_fs k=%0d got=%b exp=%b", k, frame_start, e_fs);
            end
            checks++;
            if (num !== e_num) begin
                failures++;
                $display("FAIL scan_num k=%0d got=%h exp=%h", k, num, e_num);
            end
        end
    endtask

    // Asynchronous reset while a digit is being driven
    task automatic test_reset();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (DIG !== 6'h3F) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_setup got=%h exp=active_digit", DIG);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (DIG !== 6'h3F) begin
            failures++;
            $display("FAIL reset_dig got=%h exp=3f", DIG);
        end
        checks++;
        if (num !== 5'd0) begin
            failures++;
            $display("FAIL reset_num got=%h exp=00", num);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_fs got=%b exp=0", frame_start);
        end
        @(posedge clk); #1;
        checks++;
        if (DIG !== 6'h3F) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=3f", DIG);
        end
    endtask

    // Only digits 5 and 0 enabled, then everything disabled
    task automatic test_enable();
        int idx;
        logic [5:0] e_dig;
        logic [4:0] e_num;
        logic       e_fs;
        scan_div = 16'd3; bright = 4'hF; dig_en = 6'b100001; nums = nums_a;
        apply_reset();
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            idx   = (((k / 4) % 2) == 0) ? 5 : 0;
            e_dig = ((k % 4) >= 2) ? sel(idx) : 6'h3F;
            e_fs  = ((k % 8) == 0);
            e_num = (k == 0) ? 5'd0 : dg(nums_a, idx);
            checks++;
            if (DIG !== e_dig) begin
                failures++;
                $display("FAIL en_dig k=%0d got=%h exp=%h", k, DIG, e_dig);
            end
            checks++;
            if (frame_start !== e_fs) begin
                failures++;
                $display("FAIL en_fs k=%0d got=%b exp=%b", k, frame_start, e_fs);
            end
            checks++;
            if (num !== e_num) begin
                failures++;
                $display("FAIL en_num k=%0d got=%h exp=%h", k, num, e_num);
            end
        end
        dig_en = 6'h00;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (DIG !== 6'h3F) begin
                failures++;
                $display("FAIL en_off_dig k=%0d got=%h exp=3f", k, DIG);
            end
            checks++;
            if (frame_start !== 1'b0) begin
                failures++;
                $display("FAIL en_off_fs k=%0d got=%b exp=0", k, frame_start);
            end
        end
    endtask

    // Brightness 3 within one long slot: on while pwm_cnt in 0..3
    task automatic test_pwm();
        logic [5:0] e_dig;
        int lows;
        lows = 0;
        scan_div = 16'd100; bright = 4'd3; dig_en = 6'h3F; nums = nums_a;
        apply_reset();
        for (int k = 0; k <= 100; k++) begin
            @(posedge clk); #1;
            e_dig = (k >= 2 && (k % 16) <= 3) ? sel(5) : 6'h3F;
            if (k >= 16 && k < 80 && DIG !== 6'h3F) lows++;
            checks++;
            if (DIG !== e_dig) begin
                failures++;
                $display("FAIL pwm_dig k=%0d got=%h exp=%h", k, DIG, e_dig);
            end
        end
        checks++;
        if (lows !== 16) begin
            failures++;
            $display("FAIL pwm_duty got=%0d exp=16", lows);
        end
    endtask

    // Codes changed mid-frame stay hidden until after the next frame start
    task automatic test_frame_latch();
        int idx;
        logic [4:0] e_num;
        logic       e_fs;
        scan_div = 16'd3; bright = 4'hF; dig_en = 6'h3F; nums = nums_a;
        apply_reset();
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            idx   = 5 - ((k / 4) % 6);
            e_num = (k == 0) ? 5'd0 : ((k <= 24) ? dg(nums_a, idx) : dg(nums_b, idx));
            e_fs  = ((k % 24) == 0);
            checks++;
            if (num !== e_num) begin
                failures++;
                $display("FAIL latch_num k=%0d got=%h exp=%h", k, num, e_num);
            end
            checks++;
            if (frame_start !== e_fs) begin
                failures++;
                $display("FAIL latch_fs k=%0d got=%b exp=%b", k, frame_start, e_fs);
            end
            if (k == 5) nums = nums_b;
        end
    endtask

    // scan_div=0 acts as 1: 2-cycle slots fully blanked, frames still counted
    task automatic test_div0();
        int idx;
        logic [4:0] e_num;
        logic       e_fs;
        scan_div = 16'd0; bright = 4'hF; dig_en = 6'h3F; nums = nums_a;
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            idx   = 5 - ((k / 2) % 6);
            e_fs  = ((k % 12) == 0);
            e_num = (k == 0) ? 5'd0 : dg(nums_a, idx);
            checks++;
            if (DIG !== 6'h3F) begin
                failures++;
                $display("FAIL div0_dig k=%0d got=%h exp=3f", k, DIG);
            end
            checks++;
            if (frame_start !== e_fs) begin
                failures++;
                $display("FAIL div0_fs k=%0d got=%b exp=%b", k, frame_start, e_fs);
            end
            checks++;
            if (num !== e_num) begin
                failures++;
                $display("FAIL div0_num k=%0d got=%h exp=%h", k, num, e_num);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        scan_div = 16'd3;
        bright   = 4'hF;
        dig_en   = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            nums_a[i*5 +: 5] = 5'(3 * i + 7);
            nums_b[i*5 +: 5] = 5'(31 - 2 * i);
        end
        nums = nums_a;

        test_scan();
        test_reset();
        test_enable();
        test_pwm();
        test_frame_latch();
        test_div0();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
